gpio_pattern_tester: RTL and testbench

GPIO_PATTERN_TESTER -- requirements
Module: gpio_pattern_tester

---
 rtl/gpio_pattern_pkg.sv | 19 +
 rtl/gpio_pattern_tester_if.sv | 25 ++
 rtl/gpio_edge_detect.sv | 23 ++
 rtl/gpio_pattern_tester.sv | 137 +++++++++++++
 tb/tb_gpio_pattern_tester.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pattern_pkg.sv
// Shared types for the GPIO pattern tester: pattern modes and sequencer states.
package gpio_pattern_pkg;

    localparam int ModeWidth = 2;

    typedef enum logic [1:0] {
        WALK    = 2'd0,
        COUNT   = 2'd1,
        FILL    = 2'd2,
        INVWALK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gpio_pattern_tester_if.sv
// Trigger/mode request and pattern/status response bundle of the pattern tester.
interface gpio_pattern_tester_if
    import gpio_pattern_pkg::*;
#(
    parameter int OutputWidth  = 5,
    parameter int TriggerWidth = 1,
    parameter int CounterWidth = 16
);
    logic [TriggerWidth-1:0] trigger;
    logic [ModeWidth-1:0]    mode;
    logic [OutputWidth-1:0]  out;
    logic                    busy;
    logic                    done;
    logic [CounterWidth-1:0] overrun_count;

    modport master (
        output trigger, mode,
        input  out, busy, done, overrun_count
    );

    modport slave (
        input  trigger, mode,
        output out, busy, done, overrun_count
    );
endinterface

// File: rtl/gpio_edge_detect.sv
// Rising-edge detector over a trigger bus; any bit rising yields a single edge flag.
module gpio_edge_detect #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] trigger,
    output logic             trig_edge
);
    logic [Width-1:0] trigger_q_r;

    // Previous trigger sample; loads all-ones so a level held across reset is not an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            trigger_q_r <= '1;
        end else begin
            trigger_q_r <= trigger;
        end
    end

    assign trig_edge = |(trigger & ~trigger_q_r);

endmodule

// File: rtl/gpio_pattern_tester.sv
// Triggered pattern sequencer: plays one of four patterns over OutputWidth steps,
// then pulses done; triggers arriving while busy are counted as overruns.
module gpio_pattern_tester
    import gpio_pattern_pkg::*;
#(
    parameter int OutputWidth  = 5,
    parameter int TriggerWidth = 1,
    parameter int StepCycles   = 4,
    parameter int CounterWidth = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_pattern_tester_if.slave  bus
);
    localparam int StepW = (OutputWidth > 1) ? $clog2(OutputWidth) : 1;
    localparam int CycW  = (StepCycles > 1)  ? $clog2(StepCycles)  : 1;
    localparam logic [StepW-1:0] LastStep = StepW'(OutputWidth - 1);
    localparam logic [CycW-1:0]  LastCyc  = CycW'(StepCycles - 1);

    typedef logic [OutputWidth:0] wide_t;

    // One extra bit of headroom lets FILL form bits [step:0] without overflow
    function automatic logic [OutputWidth-1:0] pattern_f(input mode_e m, input logic [StepW-1:0] s);
        wide_t one_hot_v;
        wide_t count_v;
        wide_t fill_v;
        one_hot_v = wide_t'(1) << s;
        count_v   = wide_t'(s) + wide_t'(1);
        fill_v    = wide_t'(one_hot_v << 1) - wide_t'(1);
        case (m)
            WALK:    pattern_f = one_hot_v[OutputWidth-1:0];
            COUNT:   pattern_f = count_v[OutputWidth-1:0];
            FILL:    pattern_f = fill_v[OutputWidth-1:0];
            INVWALK: pattern_f = ~one_hot_v[OutputWidth-1:0];
            default: pattern_f = '0;
        endcase
    endfunction

    state_e                  state_r, state_nxt_s;
    mode_e                   mode_r, mode_nxt_s;
    logic [StepW-1:0]        step_r, step_nxt_s;
    logic [CycW-1:0]         cyc_r, cyc_nxt_s;
    logic [OutputWidth-1:0]  out_r;
    logic                    busy_r;
    logic                    done_r;
    logic [CounterWidth-1:0] ovr_r;
    logic                    edge_s;

    gpio_edge_detect #(
        .Width (TriggerWidth)
    ) u_edge (
        .clk       (clk),
        .reset     (reset),
        .trigger   (bus.trigger),
        .trig_edge (edge_s)
    );

    // Next-state logic for the sequencer and its step/cycle counters
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        step_nxt_s  = step_r;
        cyc_nxt_s   = cyc_r;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_nxt_s = RUN;
                    mode_nxt_s  = mode_e'(bus.mode);
                    step_nxt_s  = '0;
                    cyc_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cyc_r == LastCyc) begin
                    cyc_nxt_s = '0;
                    if (step_r == LastStep) begin
                        state_nxt_s = DONE;
                        step_nxt_s  = '0;
                    end else begin
                        step_nxt_s = step_r + StepW'(1);
                    end
                end else begin
                    cyc_nxt_s = cyc_r + CycW'(1);
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state, latched mode and position registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            mode_r  <= WALK;
            step_r  <= '0;
            cyc_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            step_r  <= step_nxt_s;
            cyc_r   <= cyc_nxt_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            out_r  <= (state_nxt_s == RUN) ? pattern_f(mode_nxt_s, step_nxt_s) : '0;
            busy_r <= (state_nxt_s == RUN);
            done_r <= (state_nxt_s == DONE);
        end
    end

    // Saturating count of trigger edges that arrive while a sequence is in progress
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_r <= '0;
        end else if (edge_s && (state_r != IDLE) && (ovr_r != '1)) begin
            ovr_r <= ovr_r + CounterWidth'(1);
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign bus.out           = out_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.overrun_count = ovr_r;

endmodule

// File: tb/tb_gpio_pattern_tester.sv
// Bench for gpio_pattern_tester: two configurations driven by directed and random
// stimulus, checked every cycle against a timeline model of each sequence.
module tb_gpio_pattern_tester;

    localparam int OW     = 5;
    localparam int SC_A   = 4;
    localparam int SC_B   = 1;
    localparam int OMAX_A = 65535;
    localparam int OMAX_B = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;
    int   busy_a, busy_b, done_a, done_b;

    int m_act   [2];
    int m_start [2];
    int m_mode  [2];
    int m_prev  [2];
    int m_ovr   [2];

    gpio_pattern_tester_if #(.OutputWidth(OW), .TriggerWidth(1), .CounterWidth(16)) if_a ();
    gpio_pattern_tester_if #(.OutputWidth(OW), .TriggerWidth(3), .CounterWidth(2))  if_b ();

    gpio_pattern_tester #(.OutputWidth(OW), .TriggerWidth(1), .StepCycles(SC_A), .CounterWidth(16))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    gpio_pattern_tester #(.OutputWidth(OW), .TriggerWidth(3), .StepCycles(SC_B), .CounterWidth(2))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic int pat(input int md, input int st);
        int v;
        case (md)
            0:       v = 1 << st;
            1:       v = st + 1;
            2:       v = (1 << (st + 1)) - 1;
            3:       v = ~(1 << st);
            default: v = 0;
        endcase
        return v & ((1 << OW) - 1);
    endfunction

    // Sequence timeline: a start at clock k0 is busy for OW*sc clocks, then done for one
    task automatic model_step(input int i, input int trig, input int md, input int sc,
                              input int mask, input int omax,
                              output int eo, output int eb, output int ed);
        int d;
        bit e;
        bit inuse;
        if (reset == 1'b0) begin
            m_act[i]  = 0;
            m_prev[i] = mask;
            m_ovr[i]  = 0;
        end else begin
            e         = ((trig & ~m_prev[i] & mask) != 0);
            m_prev[i] = trig;
            inuse     = (m_act[i] != 0) && ((k - 1 - m_start[i]) <= OW * sc);
            if (e && inuse) begin
                if (m_ovr[i] < omax) m_ovr[i]++;
            end else if (e) begin
                m_act[i]   = 1;
                m_start[i] = k;
                m_mode[i]  = md;
            end
        end
        d  = k - m_start[i];
        eo = 0; eb = 0; ed = 0;
        if (m_act[i] != 0 && d < OW * sc) begin
            eo = pat(m_mode[i], d / sc);
            eb = 1;
        end else if (m_act[i] != 0 && d == OW * sc) begin
            ed = 1;
        end
    endtask

    task automatic tick();
        int eo, eb, ed;
        @(posedge clk);
        #1;
        k++;
        model_step(0, int'(if_a.trigger), int'(if_a.mode), SC_A, 1, OMAX_A, eo, eb, ed);
        check_val("a_out",  32'(if_a.out),  eo);
        check_val("a_busy", 32'(if_a.busy), eb);
        check_val("a_done", 32'(if_a.done), ed);
        check_val("a_ovr",  32'(if_a.overrun_count), m_ovr[0]);
        model_step(1, int'(if_b.trigger), int'(if_b.mode), SC_B, 7, OMAX_B, eo, eb, ed);
        check_val("b_out",  32'(if_b.out),  eo);
        check_val("b_busy", 32'(if_b.busy), eb);
        check_val("b_done", 32'(if_b.done), ed);
        check_val("b_ovr",  32'(if_b.overrun_count), m_ovr[1]);
        if (if_a.busy === 1'b1) busy_a++;
        if (if_b.busy === 1'b1) busy_b++;
        if (if_a.done === 1'b1) done_a++;
        if (if_b.done === 1'b1) done_b++;
    endtask

    task automatic clear_counts();
        busy_a = 0; busy_b = 0; done_a = 0; done_b = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_start[i] = 0; m_mode[i] = 0; m_prev[i] = 0; m_ovr[i] = 0;
        end
        clear_counts();
        reset = 1'b0;
        if_a.trigger = 1'b0;  if_a.mode = 2'd0;
        if_b.trigger = 3'b000; if_b.mode = 2'd0;
        repeat (3) tick();
        check_val("rst_a_out", 32'(if_a.out), 32'd0);
        check_val("rst_b_ovr", 32'(if_b.overrun_count), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // WALK with overruns and an ignored mode change on A; COUNT then FILL on B
        clear_counts();
        for (int j = 0; j < 30; j++) begin
            case (j)
                0: begin if_a.trigger = 1'b1; if_a.mode = 2'd0; if_b.trigger = 3'b111; if_b.mode = 2'd1; end
                2: if_a.mode = 2'd3;
                4, 6, 8: if_a.trigger = 1'b0;
                5, 7, 9: if_a.trigger = 1'b1;
                default: ;
            endcase
            if (j == 7)  if_b.trigger = 3'b000;
            if (j == 8)  begin if_b.trigger = 3'b111; if_b.mode = 2'd2; end
            if (j == 20) if_b.trigger = 3'b000;
            tick();
            if (j == 0) begin
                check_val("walk_first", 32'(if_a.out), 32'h01);
                check_val("count_first", 32'(if_b.out), 32'h01);
            end
            if (j == 12) check_val("fill_last", 32'(if_b.out), 32'h1f);
        end
        check_val("a_busy_len", 32'(busy_a), 32'd20);
        check_val("b_busy_len", 32'(busy_b), 32'd10);
        check_val("a_done_cnt", 32'(done_a), 32'd1);
        check_val("b_done_cnt", 32'(done_b), 32'd2);
        check_val("a_ovr3",     32'(if_a.overrun_count), 32'd3);
        check_val("b_ovr0",     32'(if_b.overrun_count), 32'd0);

        // Staggered bit edges on B during RUN and DONE saturate its 2-bit counter
        if_a.trigger = 1'b0;
        tick();
        for (int j = 0; j < 9; j++) begin
            case (j)
                0, 4, 8: if_b.trigger = 3'b001;
                1, 5:    if_b.trigger = 3'b011;
                2, 6:    if_b.trigger = 3'b111;
                default: if_b.trigger = 3'b000;
            endcase
            tick();
        end
        check_val("b_ovr_sat", 32'(if_b.overrun_count), 32'd3);
        check_val("b_restart", 32'(if_b.busy), 32'd1);
        if_b.trigger = 3'b000;
        repeat (8) tick();

        // Reset during step 2 aborts silently; a held trigger must not restart
        if_a.mode = 2'd1;
        if_a.trigger = 1'b1;
        repeat (9) tick();
        check_val("pre_rst_step2", 32'(if_a.out), 32'd3);
        clear_counts();
        reset = 1'b0;
        tick();
        check_val("abort_out",  32'(if_a.out),  32'd0);
        check_val("abort_busy", 32'(if_a.busy), 32'd0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check_val("held_idle", 32'(busy_a), 32'd0);
        check_val("no_done",   32'(done_a), 32'd0);
        if_a.trigger = 1'b0;
        tick();
        if_a.trigger = 1'b1;
        tick();
        check_val("rearm_busy", 32'(if_a.busy), 32'd1);
        check_val("rearm_out",  32'(if_a.out),  32'd1);
        repeat (25) tick();

        // Random traffic with occasional resets
        for (int j = 0; j < 1500; j++) begin
            reset        = ($urandom_range(0, 199) != 0);
            if_a.trigger = if_a.trigger ^ ($urandom_range(0, 5) == 0);
            if_b.trigger = if_b.trigger ^ 3'($urandom & $urandom & $urandom);
            if_a.mode    = 2'($urandom);
            if_b.mode    = 2'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
